conv_window_gen: RTL and testbench

Parametrised streaming sliding-window generator for the CNN datapath: accepts raster-order pixels, each carrying CI packed channels, and emits a KX×KY×CI window for every valid output position at a configurable stride. Row history is held in on-chip line buffers. Valid/ready backpressure on both sides lets the generator feed conv stage 1 directly, or feed stage-2 conv after pooling.

---
 rtl/conv_window_gen_if.sv | 33 +++
 rtl/conv_window_gen.sv | 108 ++++++++++
 tb/tb_conv_window_gen.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/conv_window_gen_if.sv
// conv_window_gen_if: valid/ready pixel-in / window-out bundle for conv_window_gen.
interface conv_window_gen_if #(
  parameter int I_F_BW = 8,
  parameter int CI     = 1,
  parameter int KX     = 5,
  parameter int KY     = 5,
  parameter int IX     = 28,
  parameter int IY     = 28
);
  localparam int PW = CI * I_F_BW;
  localparam int WW = KX * KY * PW;
  localparam int RW = (IY > 1) ? $clog2(IY) : 1;
  localparam int CW = (IX > 1) ? $clog2(IX) : 1;
  logic          i_valid;
  logic          i_ready;
  logic [PW-1:0] i_pixel;
  logic          i_sof;
  logic          o_valid;
  logic          o_ready;
  logic [WW-1:0] o_window;
  logic [RW-1:0] o_row;
  logic [CW-1:0] o_col;
  logic          o_last;
  logic          o_err;
  modport master (
    output i_valid, i_pixel, i_sof, o_ready,
    input  i_ready, o_valid, o_window, o_row, o_col, o_last, o_err
  );
  modport slave (
    input  i_valid, i_pixel, i_sof, o_ready,
    output i_ready, o_valid, o_window, o_row, o_col, o_last, o_err
  );
endinterface

// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming KXxKY sliding-window generator with line buffers and strided output.
// Define CONV_WINGEN_SOF_RESYNC_EN to let i_sof restart framing and raise a sticky o_err on misalignment.
module conv_window_gen #(
  parameter int I_F_BW = 8,
  parameter int CI     = 1,
  parameter int KX     = 5,
  parameter int KY     = 5,
  parameter int IX     = 28,
  parameter int IY     = 28,
  parameter int STRIDE = 1
) (
  input logic             clk,
  input logic             reset_n,
  conv_window_gen_if.slave s
);
  localparam int PW    = CI * I_F_BW;
  localparam int RW    = (IY > 1) ? $clog2(IY) : 1;
  localparam int CW    = (IX > 1) ? $clog2(IX) : 1;
  localparam int SW    = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int OUT_W = (IX - KX) / STRIDE + 1;
  localparam int OUT_H = (IY - KY) / STRIDE + 1;
  logic [KY-1:0][KX-1:0][PW-1:0] win_q, win_d, ow_q, ow_d;
  logic [KY-1:0][PW-1:0] lb_rd;
  logic [PW-1:0] lb_mem [KY-1][IX];
  logic [CW-1:0] col_q, col_d, col, oc_q, oc_d, oc, ocol_q, ocol_d;
  logic [RW-1:0] row_q, row_d, row, or_q, or_d, orr, orow_q, orow_d;
  logic [SW-1:0] sx_q, sx_d, sx, sy_q, sy_d, sy;
  logic ov_q, ov_d, last_q, last_d, err_q, err_d;
  logic acc, sof, emit, col_ok, row_ok, eol;
`ifndef CONV_WINGEN_SOF_RESYNC_EN
  logic unused_sof;
  assign unused_sof = s.i_sof;
`endif
  assign s.i_ready  = !ov_q || s.o_ready;
  assign s.o_valid  = ov_q;
  assign s.o_window = ow_q;
  assign s.o_row    = orow_q;
  assign s.o_col    = ocol_q;
  assign s.o_last   = last_q;
  assign s.o_err    = err_q;
  always_comb begin
    acc = s.i_valid && s.i_ready;
`ifdef CONV_WINGEN_SOF_RESYNC_EN
    sof = s.i_sof;
`else
    sof = 1'b0;
`endif
    col = sof ? '0 : col_q;
    row = sof ? '0 : row_q;
    // Phases and output indices restart at the first eligible column/row, so stale values never leak
    sx = (col == CW'(KX-1)) ? '0 : sx_q;
    oc = (col == CW'(KX-1)) ? '0 : oc_q;
    sy = (row == RW'(KY-1)) ? '0 : sy_q;
    orr = (row == RW'(KY-1)) ? '0 : or_q;
    col_ok = col >= CW'(KX-1);
    row_ok = row >= RW'(KY-1);
    eol = col == CW'(IX-1);
    emit = acc && row_ok && col_ok && sx == '0 && sy == '0;
    col_d = acc ? (eol ? '0 : col + 1'b1) : col_q;
    row_d = (acc && eol) ? ((row == RW'(IY-1)) ? '0 : row + 1'b1) : row_q;
    sx_d = (acc && col_ok) ? ((sx == SW'(STRIDE-1)) ? '0 : sx + 1'b1) : sx_q;
    oc_d = (acc && col_ok) ? ((sx == '0) ? oc + 1'b1 : oc) : oc_q;
    sy_d = (acc && eol && row_ok) ? ((sy == SW'(STRIDE-1)) ? '0 : sy + 1'b1) : sy_q;
    or_d = (acc && eol && row_ok) ? ((sy == '0) ? orr + 1'b1 : orr) : or_q;
    lb_rd[KY-1] = s.i_pixel;
    for (int r = 0; r < KY-1; r++) lb_rd[r] = lb_mem[r][col];
    for (int r = 0; r < KY; r++) win_d[r] = acc ? {lb_rd[r], win_q[r][KX-1:1]} : win_q[r];
    ov_d = emit || (ov_q && !s.o_ready);
    ow_d = emit ? win_d : ow_q;
    orow_d = emit ? orr : orow_q;
    ocol_d = emit ? oc : ocol_q;
    last_d = emit ? (orr == RW'(OUT_H-1) && oc == CW'(OUT_W-1)) : last_q;
    err_d = err_q || (acc && sof && (col_q != '0 || row_q != '0));
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      col_q <= '0;
      row_q <= '0;
      sx_q <= '0;
      sy_q <= '0;
      oc_q <= '0;
      or_q <= '0;
      win_q <= '0;
      ov_q <= 1'b0;
      ow_q <= '0;
      orow_q <= '0;
      ocol_q <= '0;
      last_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
      oc_q <= oc_d;
      or_q <= or_d;
      win_q <= win_d;
      ov_q <= ov_d;
      ow_q <= ow_d;
      orow_q <= orow_d;
      ocol_q <= ocol_d;
      last_q <= last_d;
      err_q <= err_d;
    end
  // Cascaded line buffers: buffer r is fed with what window row r+1 sees
  always_ff @(posedge clk)
    if (acc) for (int r = 0; r < KY-1; r++) lb_mem[r][col] <= lb_rd[r+1];
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: scoreboard bench for conv_window_gen (stride 1 / CI 1 and stride 2 / CI 3 instances).
`timescale 1ns/1ps
module tb_conv_window_gen;
  localparam int KX = 5, KY = 5, IX = 28, IY = 28;
  localparam int W1 = KX*KY*8, W2 = KX*KY*3*8;
  typedef struct { logic [W2-1:0] w; int row; int col; bit last; } exp_t;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  conv_window_gen_if #(.CI(1)) if1 ();
  conv_window_gen_if #(.CI(3)) if2 ();
  conv_window_gen #(.CI(1), .STRIDE(1)) dut1 (.clk(clk), .reset_n(rst_n), .s(if1));
  conv_window_gen #(.CI(3), .STRIDE(2)) dut2 (.clk(clk), .reset_n(rst_n), .s(if2));
  exp_t q1[$], q2[$];
  exp_t e1, e2;
  int n_cmp = 0, n_bad = 0;
  bit stall = 0, dead = 0, held = 0;
  int mrow = 0, mcol = 0, seed = 0, r2 = 0, c2 = 0;
  logic [W2-1:0] hv, cur;

  task automatic chk(input string name, input logic [W2-1:0] act, input logic [W2-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pv(input int r, input int c, input int sd);
    return 8'((r*IX + c + sd) & 255);
  endfunction

  function automatic bit mk(input int row, input int col, input int st, input int ci, input int sd, output exp_t e);
    int wr = row - (KY-1), wc = col - (KX-1);
    e.w = '0; e.row = 0; e.col = 0; e.last = 0;
    if (wr < 0 || wc < 0 || wr % st != 0 || wc % st != 0) return 0;
    e.row = wr / st;
    e.col = wc / st;
    e.last = (e.row == (IY-KY)/st) && (e.col == (IX-KX)/st);
    for (int r = 0; r < KY; r++)
      for (int c = 0; c < KX; c++)
        for (int ch = 0; ch < ci; ch++)
          e.w[((r*KX + c)*ci + ch)*8 +: 8] = pv(wr + r, wc + c, sd) + 8'(ch);
    return 1;
  endfunction

  task automatic beat(input bit two, input bit sof);
    bit acc = 0;
    int t = 0;
    exp_t e;
    if (dead) return;
    if (two) begin
      if2.i_valid = 1;
      if2.i_pixel = {pv(r2, c2, 0) + 8'd2, pv(r2, c2, 0) + 8'd1, pv(r2, c2, 0)};
      if (mk(r2, c2, 2, 3, 0, e)) q2.push_back(e);
    end else begin
      if1.i_valid = 1;
      if1.i_pixel = pv(mrow, mcol, seed);
      if1.i_sof = sof;
      if (mk(mrow, mcol, 1, 1, seed, e)) q1.push_back(e);
    end
    do begin
      if1.o_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1 acc = two ? if2.i_ready : if1.i_ready;
      @(posedge clk); #1;
      t++;
    end while (!acc && t < 200);
    if1.i_valid = 0; if1.i_sof = 0; if2.i_valid = 0;
    if (!acc) begin
      n_cmp++; n_bad++; dead = 1;
      $display("FAIL accept_timeout: i_ready stayed 0 for %0d cycles, required 1", t);
    end
    if (two) begin
      c2++;
      if (c2 == IX) begin c2 = 0; r2 = (r2 == IY-1) ? 0 : r2 + 1; end
    end else begin
      mcol++;
      if (mcol == IX) begin mcol = 0; mrow = (mrow == IY-1) ? 0 : mrow + 1; end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      if1.o_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((q1.size() != 0 || q2.size() != 0) && t < 3000) begin idle(1); t++; end
    idle(3);
    chk("drain_q1_left", W2'(q1.size()), '0);
    chk("drain_q2_left", W2'(q2.size()), '0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) held = 0;
    else if (if1.o_valid) begin
      cur = W2'({if1.o_window, if1.o_row, if1.o_col, if1.o_last});
      if (held) chk("stall_hold", cur, hv);
      if (!if1.o_ready) begin
        chk("stall_i_ready", W2'(if1.i_ready), '0);
        hv = cur;
        held = 1;
      end else begin
        held = 0;
        if (q1.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL dut1_extra: window (%0d,%0d) arrived, required none", if1.o_row, if1.o_col);
        end else begin
          e1 = q1.pop_front();
          chk("dut1_window", W2'(if1.o_window), e1.w);
          chk("dut1_row_col_last", W2'({if1.o_row, if1.o_col, if1.o_last}), W2'({5'(e1.row), 5'(e1.col), e1.last}));
          if (seed == 0 && e1.row == 0 && e1.col == 0)
            chk("dut1_first_el44_el12", W2'({if1.o_window[199:192], if1.o_window[63:56]}), W2'({8'd116, 8'd30}));
        end
      end
    end else held = 0;
  end

  always @(negedge clk) begin
    if (rst_n && if2.o_valid) begin
      if (q2.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL dut2_extra: window (%0d,%0d) arrived, required none", if2.o_row, if2.o_col);
      end else begin
        e2 = q2.pop_front();
        chk("dut2_window", W2'(if2.o_window), e2.w);
        chk("dut2_row_col_last", W2'({if2.o_row, if2.o_col, if2.o_last}), W2'({5'(e2.row), 5'(e2.col), e2.last}));
        if (e2.row == 1 && e2.col == 1)
          chk("dut2_w11_el00", W2'(if2.o_window[23:0]), W2'(24'h3C3B3A));
      end
    end
  end

  initial begin
    if1.i_valid = 0; if1.i_pixel = '0; if1.i_sof = 0; if1.o_ready = 1;
    if2.i_valid = 0; if2.i_pixel = '0; if2.i_sof = 0; if2.o_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_i_ready", W2'(if1.i_ready), W2'(1));
    chk("rst_o_valid", W2'(if1.o_valid), '0);
    chk("rst_o_window", W2'(if1.o_window), '0);
    chk("rst_row_col_last", W2'({if1.o_row, if1.o_col, if1.o_last}), '0);
    chk("rst_o_err", W2'(if1.o_err), '0);
    @(posedge clk); #1 rst_n = 1;
    seed = 0;
    repeat (IX*IY) beat(0, 0);
    drain();
    seed = 7; stall = 1;
    repeat (IX*IY) beat(0, 0);
    drain();
    stall = 0; seed = 0;
    repeat (2*IX*IY) beat(0, 0);
    drain();
    seed = 3;
    repeat (300) beat(0, 0);
    rst_n = 0;
    q1.delete();
    mrow = 0; mcol = 0;
    @(negedge clk);
    chk("midrst_o_valid", W2'(if1.o_valid), '0);
    chk("midrst_i_ready", W2'(if1.i_ready), W2'(1));
    @(posedge clk); #1 rst_n = 1;
    seed = 0;
    repeat (IX*IY) beat(0, 0);
    drain();
    repeat (IX*IY) beat(1, 0);
    drain();
    seed = 9;
    repeat (50) beat(0, 0);
`ifdef CONV_WINGEN_SOF_RESYNC_EN
    mrow = 0; mcol = 0;
`endif
    beat(0, 1);
    repeat (IX*IY - 1) beat(0, 0);
    drain();
`ifdef CONV_WINGEN_SOF_RESYNC_EN
    chk("sof_err_set", W2'(if1.o_err), W2'(1));
    idle(5);
    chk("sof_err_sticky", W2'(if1.o_err), W2'(1));
`else
    chk("sof_err_tied", W2'(if1.o_err), '0);
    idle(5);
    chk("sof_err_tied_later", W2'(if1.o_err), '0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
